fp_mac_arbiter: RTL and testbench



---
 rtl/fp_mac_arbiter_pkg.sv | 39 +++
 rtl/fp_mac_arbiter_tag_table.sv | 65 ++++++
 rtl/fp_mac_arbiter.sv | 122 ++++++++++++
 tb/tb_fp_mac_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mac_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mac_arbiter_pkg
//  Description : Shared types for the FP MAC arbiter and its slot tag table.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_mac_arbiter_pkg;

    localparam int ID_WIDTH      = 4;
    // FloPoCo single precision: 2 exception bits + sign + 8 exp + 23 mantissa
    localparam int FLOPOCO_WIDTH = 34;

    typedef logic [ID_WIDTH-1:0]      id_t;
    typedef logic [FLOPOCO_WIDTH-1:0] flopoco_t;

    typedef struct packed {
        flopoco_t   rs1;
        flopoco_t   rs2;
        flopoco_t   rs3;
        logic [1:0] op;
    } fp_mac_inputs_t;

    typedef enum logic {
        FP_MAC_SRC_ISSUE = 1'b0,
        FP_MAC_SRC_AUX   = 1'b1
    } fp_mac_src_t;

    typedef struct packed {
        logic        valid;
        fp_mac_src_t src;
        id_t         orig_id;
    } fp_mac_slot_t;

    function automatic fp_mac_src_t port_to_src(input logic port);
        return port ? FP_MAC_SRC_AUX : FP_MAC_SRC_ISSUE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mac_arbiter_tag_table.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mac_tag_table
//  Description : Outstanding-op slot array with lowest-free allocation,
//                index lookup and free-by-index.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_mac_tag_table
    import fp_mac_arbiter_pkg::*;
#(
    parameter int NUM_SLOTS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         alloc_en,
    input  fp_mac_src_t  alloc_src,
    input  id_t          alloc_orig_id,
    output id_t          alloc_idx,
    output logic         any_free,
    input  logic         free_en,
    input  id_t          free_idx,
    input  id_t          lookup_idx,
    output fp_mac_slot_t lookup_slot
);

    fp_mac_slot_t r_slots [NUM_SLOTS];

    // Descending scan so the lowest free index wins
    always_comb begin
        any_free  = 1'b0;
        alloc_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_slots[i].valid) begin
                any_free  = 1'b1;
                alloc_idx = id_t'(i);
            end
        end
    end

    // Out-of-range indices read back as an invalid slot
    always_comb begin
        lookup_slot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (lookup_idx == id_t'(i)) begin
                lookup_slot = r_slots[i];
            end
        end
    end

    // Allocation targets a free slot and freeing targets a valid one,
    // so the two never address the same entry in one cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (rst) begin
                r_slots[i] <= '0;
            end else if (alloc_en && alloc_idx == id_t'(i)) begin
                r_slots[i] <= '{valid: 1'b1, src: alloc_src, orig_id: alloc_orig_id};
            end else if (free_en && free_idx == id_t'(i)) begin
                r_slots[i].valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_mac_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mac_arbiter
//  Description : Round-robin sharing of one FP MAC between the issue path
//                (port 0) and an aux sequencer (port 1), with tag remapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_mac_arbiter
    import fp_mac_arbiter_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int AUX_MAX   = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  fp_mac_inputs_t req_inputs [2],
    input  id_t            req_id [2],
    output fp_mac_inputs_t mac_inputs,
    output logic           mac_new_request,
    input  logic           mac_ready,
    output id_t            mac_id,
    input  logic           mac_done,
    input  id_t            mac_wb_id,
    input  flopoco_t       mac_rd,
    output logic           mac_ack,
    output logic [1:0]     rsp_done,
    output id_t            rsp_id [2],
    output flopoco_t       rsp_rd [2],
    input  logic [1:0]     rsp_ack
);

    localparam int CNT_W = $clog2(AUX_MAX + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t AUX_LIMIT = cnt_t'(AUX_MAX);

    logic         r_rr;
    cnt_t         r_aux_cnt;
    logic         w_any_free;
    id_t          w_alloc_idx;
    logic         w_elig0;
    logic         w_elig1;
    logic         w_grant;
    logic         w_grant_port;
    fp_mac_slot_t w_slot;
    logic         w_hit;
    logic         w_owner;
    logic         w_aux_inc;
    logic         w_aux_dec;

    // Issue side: ready is a function of valid/bookkeeping only, never operands
    always_comb begin
        w_elig0      = req_valid[0];
        w_elig1      = req_valid[1] && (r_aux_cnt < AUX_LIMIT);
        w_grant      = !rst && mac_ready && w_any_free && (w_elig0 || w_elig1);
        w_grant_port = (w_elig0 && w_elig1) ? r_rr : w_elig1;
        req_ready[0] = w_grant && !w_grant_port;
        req_ready[1] = w_grant &&  w_grant_port;
    end

    assign mac_new_request = w_grant;
    assign mac_id          = w_alloc_idx;
    assign mac_inputs      = w_grant ? req_inputs[w_grant_port] : req_inputs[0];

    // Writeback side: route to the slot owner and restore its id
    always_comb begin
        w_hit       = !rst && mac_done && w_slot.valid;
        w_owner     = (w_slot.src == FP_MAC_SRC_AUX);
        rsp_done[0] = w_hit && !w_owner;
        rsp_done[1] = w_hit &&  w_owner;
        mac_ack     = w_hit && rsp_ack[w_owner];
        rsp_id[0]   = w_slot.orig_id;
        rsp_id[1]   = w_slot.orig_id;
        rsp_rd[0]   = mac_rd;
        rsp_rd[1]   = mac_rd;
    end

    assign w_aux_inc = w_grant && w_grant_port;
    assign w_aux_dec = mac_ack && w_owner;

    fp_mac_tag_table #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_tag_table (
        .clk           (clk),
        .rst           (rst),
        .alloc_en      (w_grant),
        .alloc_src     (port_to_src(w_grant_port)),
        .alloc_orig_id (req_id[w_grant_port]),
        .alloc_idx     (w_alloc_idx),
        .any_free      (w_any_free),
        .free_en       (mac_ack),
        .free_idx      (mac_wb_id),
        .lookup_idx    (mac_wb_id),
        .lookup_slot   (w_slot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr      <= 1'b0;
            r_aux_cnt <= '0;
        end else begin
            if (w_grant) begin
                r_rr <= !w_grant_port;
            end
            if (w_aux_inc && !w_aux_dec) begin
                r_aux_cnt <= r_aux_cnt + cnt_t'(1);
            end else if (w_aux_dec && !w_aux_inc) begin
                r_aux_cnt <= r_aux_cnt - cnt_t'(1);
            end
        end
    end

    // A writeback for a slot that is not outstanding is a MAC protocol error
    always_ff @(posedge clk) begin
        if (!rst && mac_done) begin
            assert (w_slot.valid);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_mac_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_mac_arbiter
//  Description : Directed vector table plus randomized traffic against a
//                slot-occupancy reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mac_arbiter;
    import fp_mac_arbiter_pkg::*;

    localparam int NUM_SLOTS = 8;
    localparam int AUX_MAX   = 2;
    localparam int NVEC      = 29;

    logic           clk;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    fp_mac_inputs_t req_inputs [2];
    id_t            req_id [2];
    fp_mac_inputs_t mac_inputs;
    logic           mac_new_request;
    logic           mac_ready;
    id_t            mac_id;
    logic           mac_done;
    id_t            mac_wb_id;
    flopoco_t       mac_rd;
    logic           mac_ack;
    logic [1:0]     rsp_done;
    id_t            rsp_id [2];
    flopoco_t       rsp_rd [2];
    logic [1:0]     rsp_ack;

    int checks = 0;
    int errors = 0;

    fp_mac_arbiter #(
        .NUM_SLOTS (NUM_SLOTS),
        .AUX_MAX   (AUX_MAX)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_inputs      (req_inputs),
        .req_id          (req_id),
        .mac_inputs      (mac_inputs),
        .mac_new_request (mac_new_request),
        .mac_ready       (mac_ready),
        .mac_id          (mac_id),
        .mac_done        (mac_done),
        .mac_wb_id       (mac_wb_id),
        .mac_rd          (mac_rd),
        .mac_ack         (mac_ack),
        .rsp_done        (rsp_done),
        .rsp_id          (rsp_id),
        .rsp_rd          (rsp_rd),
        .rsp_ack         (rsp_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] rv;
        logic       mr;
        id_t        id0;
        id_t        id1;
        logic       md;
        id_t        wb;
        logic [1:0] rack;
        logic [1:0] e_rdy;
        id_t        e_mid;
        logic [1:0] e_done;
        id_t        e_rid;
        logic       e_ack;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic [1:0] rv, input logic mr,
                                input int id0, input int id1, input logic md, input int wb,
                                input logic [1:0] rack, input logic [1:0] e_rdy, input int e_mid,
                                input logic [1:0] e_done, input int e_rid, input logic e_ack);
        vec_t v;
        v.rst = r; v.rv = rv; v.mr = mr; v.id0 = id_t'(id0); v.id1 = id_t'(id1);
        v.md = md; v.wb = id_t'(wb); v.rack = rack; v.e_rdy = e_rdy; v.e_mid = id_t'(e_mid);
        v.e_done = e_done; v.e_rid = id_t'(e_rid); v.e_ack = e_ack;
        return v;
    endfunction

    function automatic fp_mac_inputs_t rnd_inputs();
        fp_mac_inputs_t x;
        x.rs1 = flopoco_t'({$urandom, $urandom});
        x.rs2 = flopoco_t'({$urandom, $urandom});
        x.rs3 = flopoco_t'({$urandom, $urandom});
        x.op  = 2'($urandom);
        return x;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: what is outstanding, who owns it, and arbitration history
    bit  m_busy  [NUM_SLOTS];
    int  m_owner [NUM_SLOTS];
    id_t m_oid   [NUM_SLOTS];
    int  m_aux;
    int  m_rr;

    task automatic model_reset();
        for (int i = 0; i < NUM_SLOTS; i++) begin
            m_busy[i] = 0; m_owner[i] = 0; m_oid[i] = '0;
        end
        m_aux = 0;
        m_rr  = 0;
    endtask

    initial begin
        int   free_slot;
        int   g;
        int   o;
        int   k;
        int   busy_q [$];
        logic [1:0] e_rdy;
        logic [1:0] e_done;
        logic e_ack;

        // single op and writeback
        vecs[0]  = mk(0, 2'b01, 1,  5, 0, 0, 0, 2'b00, 2'b01, 0, 2'b00, 0, 0);
        vecs[1]  = mk(0, 2'b00, 1,  0, 0, 1, 0, 2'b01, 2'b00, 0, 2'b01, 5, 1);
        // out-of-order return and lowest-first reuse
        vecs[2]  = mk(0, 2'b01, 1,  1, 0, 0, 0, 2'b00, 2'b01, 0, 2'b00, 0, 0);
        vecs[3]  = mk(0, 2'b01, 1,  2, 0, 0, 0, 2'b00, 2'b01, 1, 2'b00, 0, 0);
        vecs[4]  = mk(0, 2'b00, 1,  0, 0, 1, 1, 2'b01, 2'b00, 0, 2'b01, 2, 1);
        vecs[5]  = mk(0, 2'b00, 1,  0, 0, 1, 0, 2'b01, 2'b00, 0, 2'b01, 1, 1);
        vecs[6]  = mk(0, 2'b01, 1,  3, 0, 0, 0, 2'b00, 2'b01, 0, 2'b00, 0, 0);
        vecs[7]  = mk(0, 2'b01, 1,  4, 0, 0, 0, 2'b00, 2'b01, 1, 2'b00, 0, 0);
        vecs[8]  = mk(0, 2'b01, 0,  7, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0);
        vecs[9]  = mk(0, 2'b00, 1,  0, 0, 1, 0, 2'b01, 2'b00, 0, 2'b01, 3, 1);
        vecs[10] = mk(0, 2'b00, 1,  0, 0, 1, 1, 2'b01, 2'b00, 0, 2'b01, 4, 1);
        // reset, then contention until full
        vecs[11] = mk(1, 2'b11, 1,  0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0);
        vecs[12] = mk(0, 2'b11, 1, 10, 6, 0, 0, 2'b00, 2'b01, 0, 2'b00, 0, 0);
        vecs[13] = mk(0, 2'b11, 1, 11, 6, 0, 0, 2'b00, 2'b10, 1, 2'b00, 0, 0);
        vecs[14] = mk(0, 2'b11, 1, 12, 7, 0, 0, 2'b00, 2'b01, 2, 2'b00, 0, 0);
        vecs[15] = mk(0, 2'b11, 1, 13, 9, 0, 0, 2'b00, 2'b10, 3, 2'b00, 0, 0);
        vecs[16] = mk(0, 2'b11, 1, 14, 7, 0, 0, 2'b00, 2'b01, 4, 2'b00, 0, 0);
        vecs[17] = mk(0, 2'b11, 1, 15, 7, 0, 0, 2'b00, 2'b01, 5, 2'b00, 0, 0);
        vecs[18] = mk(0, 2'b11, 1,  8, 7, 0, 0, 2'b00, 2'b01, 6, 2'b00, 0, 0);
        vecs[19] = mk(0, 2'b11, 1,  9, 7, 0, 0, 2'b00, 2'b01, 7, 2'b00, 0, 0);
        vecs[20] = mk(0, 2'b11, 1,  0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0);
        // aux backpressure (only port 0 acks, which must not count)
        vecs[21] = mk(0, 2'b01, 1,  0, 0, 1, 1, 2'b01, 2'b00, 0, 2'b10, 6, 0);
        vecs[22] = mk(0, 2'b01, 1,  0, 0, 1, 1, 2'b01, 2'b00, 0, 2'b10, 6, 0);
        vecs[23] = mk(0, 2'b01, 1,  0, 0, 1, 1, 2'b01, 2'b00, 0, 2'b10, 6, 0);
        // free at full occupancy: no grant now, freed index next, aux uncapped
        vecs[24] = mk(0, 2'b01, 1,  0, 0, 1, 1, 2'b10, 2'b00, 0, 2'b10, 6, 1);
        vecs[25] = mk(0, 2'b11, 1,  0, 5, 0, 0, 2'b00, 2'b10, 1, 2'b00, 0, 0);
        // reset with slots in flight
        vecs[26] = mk(1, 2'b11, 1,  0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0);
        vecs[27] = mk(0, 2'b11, 1,  2, 3, 0, 0, 2'b00, 2'b01, 0, 2'b00, 0, 0);
        vecs[28] = mk(0, 2'b10, 1,  2, 3, 0, 0, 2'b00, 2'b10, 1, 2'b00, 0, 0);

        rst = 1'b1; req_valid = '0; mac_ready = 1'b0; mac_done = 1'b0;
        mac_wb_id = '0; mac_rd = '0; rsp_ack = '0;
        for (int p = 0; p < 2; p++) begin
            req_inputs[p] = '0; req_id[p] = '0;
        end
        repeat (2) @(posedge clk);

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk); #1;
            rst           = vecs[i].rst;
            req_valid     = vecs[i].rv;
            mac_ready     = vecs[i].mr;
            req_id[0]     = vecs[i].id0;
            req_id[1]     = vecs[i].id1;
            req_inputs[0] = rnd_inputs();
            req_inputs[1] = rnd_inputs();
            mac_done      = vecs[i].md;
            mac_wb_id     = vecs[i].wb;
            rsp_ack       = vecs[i].rack;
            mac_rd        = (i == 1) ? 34'h0_3F80_0000 : flopoco_t'({$urandom, $urandom});
            #4;
            chk($sformatf("v%0d req_ready", i), 128'(req_ready), 128'(vecs[i].e_rdy));
            chk($sformatf("v%0d mac_new_request", i), 128'(mac_new_request), 128'(|vecs[i].e_rdy));
            if (|vecs[i].e_rdy) begin
                chk($sformatf("v%0d mac_id", i), 128'(mac_id), 128'(vecs[i].e_mid));
                chk($sformatf("v%0d mac_inputs", i), 128'(mac_inputs),
                    128'(req_inputs[vecs[i].e_rdy[1]]));
            end
            chk($sformatf("v%0d rsp_done", i), 128'(rsp_done), 128'(vecs[i].e_done));
            chk($sformatf("v%0d mac_ack", i), 128'(mac_ack), 128'(vecs[i].e_ack));
            for (int p = 0; p < 2; p++) begin
                if (vecs[i].e_done[p]) begin
                    chk($sformatf("v%0d rsp_id%0d", i, p), 128'(rsp_id[p]), 128'(vecs[i].e_rid));
                    chk($sformatf("v%0d rsp_rd%0d", i, p), 128'(rsp_rd[p]), 128'(mac_rd));
                end
            end
        end

        // Randomized traffic against the reference model, starting from reset
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; mac_done = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            rst           = ($urandom_range(0, 79) == 0);
            req_valid     = 2'($urandom);
            mac_ready     = ($urandom_range(0, 3) != 0);
            req_id[0]     = id_t'($urandom);
            req_id[1]     = id_t'($urandom);
            req_inputs[0] = rnd_inputs();
            req_inputs[1] = rnd_inputs();
            rsp_ack       = 2'($urandom);
            mac_rd        = flopoco_t'({$urandom, $urandom});
            busy_q.delete();
            for (int s = 0; s < NUM_SLOTS; s++) if (m_busy[s]) busy_q.push_back(s);
            mac_done  = 1'b0;
            mac_wb_id = id_t'($urandom);
            if (busy_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                mac_done  = 1'b1;
                mac_wb_id = id_t'(busy_q[$urandom_range(0, busy_q.size() - 1)]);
            end
            #4;
            free_slot = -1;
            for (int s = NUM_SLOTS - 1; s >= 0; s--) if (!m_busy[s]) free_slot = s;
            g = -1;
            if (!rst && mac_ready && free_slot >= 0) begin
                if (req_valid[0] && req_valid[1] && m_aux < AUX_MAX) g = m_rr;
                else if (req_valid[0]) g = 0;
                else if (req_valid[1] && m_aux < AUX_MAX) g = 1;
            end
            e_rdy  = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
            e_done = 2'b00;
            e_ack  = 1'b0;
            o      = 0;
            k      = int'(mac_wb_id);
            if (!rst && mac_done) begin
                o         = m_owner[k];
                e_done[o] = 1'b1;
                e_ack     = rsp_ack[o];
            end
            chk("rnd req_ready", 128'(req_ready), 128'(e_rdy));
            chk("rnd mac_new_request", 128'(mac_new_request), 128'(g >= 0));
            if (g >= 0) begin
                chk("rnd mac_id", 128'(mac_id), 128'(free_slot));
                chk("rnd mac_inputs", 128'(mac_inputs), 128'(req_inputs[g]));
            end
            chk("rnd rsp_done", 128'(rsp_done), 128'(e_done));
            chk("rnd mac_ack", 128'(mac_ack), 128'(e_ack));
            if (e_done != 2'b00) begin
                chk("rnd rsp_id", 128'(rsp_id[o]), 128'(m_oid[k]));
                chk("rnd rsp_rd", 128'(rsp_rd[o]), 128'(mac_rd));
            end
            if (rst) begin
                model_reset();
            end else begin
                if (e_ack) begin
                    m_busy[k] = 0;
                    if (o == 1) m_aux--;
                end
                if (g >= 0) begin
                    m_busy[free_slot]  = 1;
                    m_owner[free_slot] = g;
                    m_oid[free_slot]   = req_id[g];
                    if (g == 1) m_aux++;
                    m_rr = 1 - g;
                end
            end
        end

        @(posedge clk); #1;
        rst = 1'b1; mac_done = 1'b0; req_valid = '0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
